// File: rtl/job_pkg.sv
// Shared definitions for the job manager dispatch path: descriptor field
// offsets, dispatcher FSM encoding and a round-robin search helper.
package job_pkg;

  localparam int MAX_ENGINES = 16;
  localparam int MAX_IDX_W   = 4;
  localparam int N_W         = MAX_IDX_W + 1;
  localparam int PASID_LSB   = 992;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } disp_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping at n (ptr < n <= MAX_ENGINES).
  function automatic rr_pick_t rr_find_first(input logic [MAX_ENGINES-1:0] req,
                                             input logic [MAX_IDX_W-1:0]   ptr,
                                             input logic [N_W-1:0]         n);
    rr_pick_t       pick;
    logic [N_W-1:0] k;
    pick = '0;
    for (int i = 0; i < MAX_ENGINES; i++) begin
      k = {1'b0, ptr} + N_W'(i);
      if (k >= n) k = k - n;
      if (!pick.found && (N_W'(i) < n) && req[k[MAX_IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = k[MAX_IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/job_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// the pointer, wrapping around, and returns it one-hot and as an index.
module rr_arbiter
  import job_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [MAX_ENGINES-1:0] req_ext;
  logic [MAX_IDX_W-1:0]   ptr_ext;
  rr_pick_t               pick;

  always_comb begin
    req_ext = MAX_ENGINES'(req_i);
    ptr_ext = MAX_IDX_W'(ptr_i);
    pick    = rr_find_first(req_ext, ptr_ext, N_W'(N));
    any_o   = pick.found;
    idx_o   = pick.idx[IW-1:0];
    grant_o = '0;
    for (int j = 0; j < N; j++) begin
      grant_o[j] = pick.found && (pick.idx == MAX_IDX_W'(j));
    end
  end

endmodule

// File: rtl/job_dispatcher.sv
// Pops descriptors from the job manager FIFO and offers each one to a free
// action engine chosen round-robin; tracks engine busy state and counts.
module job_dispatcher
  import job_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int DATA_WIDTH  = 1024,
  parameter int PASID_WIDTH = 9,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable_i,
  input  logic                   dsc_ready_i,
  input  logic [DATA_WIDTH-1:0]  dsc_data_i,
  output logic                   dsc_pull_o,
  output logic [NUM_ENGINES-1:0] eng_valid_o,
  input  logic [NUM_ENGINES-1:0] eng_ready_i,
  output logic [DATA_WIDTH-1:0]  eng_dsc_o,
  output logic [PASID_WIDTH-1:0] eng_pasid_o,
  input  logic [NUM_ENGINES-1:0] eng_done_i,
  output logic [NUM_ENGINES-1:0] eng_busy_o,
  output logic [CNT_WIDTH-1:0]   dispatched_cnt_o,
  output logic [CNT_WIDTH-1:0]   completed_cnt_o,
  output logic                   idle_o,
  output logic                   err_done_o
);

  localparam int IW = $clog2(NUM_ENGINES);

  // Engine handshake: an offer (eng_valid_o[k]) stays asserted with a stable
  // descriptor until the granted engine raises eng_ready_i[k]; the transfer
  // happens on the clock edge where both are high.

  disp_state_e            state_q, state_d;
  logic [NUM_ENGINES-1:0] busy_q, busy_d;
  logic [NUM_ENGINES-1:0] grant_q, grant_d;
  logic [IW-1:0]          grant_idx_q, grant_idx_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;
  logic [CNT_WIDTH-1:0]   disp_cnt_q, disp_cnt_d;
  logic [CNT_WIDTH-1:0]   comp_cnt_q, comp_cnt_d;
  logic                   err_done_q, err_done_d;

  logic [NUM_ENGINES-1:0] arb_grant;
  logic [IW-1:0]          arb_idx;
  logic                   arb_any;
  logic                   go;
  logic                   accept;
  logic [NUM_ENGINES-1:0] done_valid;
  logic [CNT_WIDTH-1:0]   done_cnt;

  // Grant uses the registered busy vector, so a freed engine is only
  // grantable the cycle after its done pulse.
  rr_arbiter #(.N(NUM_ENGINES)) u_arb (
    .req_i  (~busy_q),
    .ptr_i  (rr_ptr_q),
    .grant_o(arb_grant),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  assign go     = (state_q == ST_IDLE) && enable_i && dsc_ready_i && arb_any;
  assign accept = (state_q == ST_OFFER) && ((grant_q & eng_ready_i) != '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      busy_q      <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      hold_q      <= '0;
      disp_cnt_q  <= '0;
      comp_cnt_q  <= '0;
      err_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      disp_cnt_q  <= disp_cnt_d;
      comp_cnt_q  <= comp_cnt_d;
      err_done_q  <= err_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (go)     state_d = ST_OFFER;
      ST_OFFER: if (accept) state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done_valid  = eng_done_i & busy_q;
    busy_d      = (busy_q & ~done_valid) | (accept ? grant_q : '0);
    done_cnt    = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      done_cnt = done_cnt + CNT_WIDTH'(done_valid[i]);
    end
    comp_cnt_d  = comp_cnt_q + done_cnt;
    disp_cnt_d  = disp_cnt_q + CNT_WIDTH'(accept);
    err_done_d  = err_done_q | ((eng_done_i & ~busy_q) != '0);
    hold_d      = go ? dsc_data_i : hold_q;
    grant_d     = go ? arb_grant : grant_q;
    grant_idx_d = go ? arb_idx : grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx_q == IW'(NUM_ENGINES - 1)) ? '0 : grant_idx_q + 1'b1;
    end
  end

  // Pull is masked during reset so the FIFO head is not lost to a capture
  // that reset would immediately discard.
  always_comb begin
    dsc_pull_o       = go && resetn;
    eng_valid_o      = (state_q == ST_OFFER) ? grant_q : '0;
    eng_dsc_o        = hold_q;
    eng_pasid_o      = hold_q[PASID_LSB +: PASID_WIDTH];
    eng_busy_o       = busy_q;
    dispatched_cnt_o = disp_cnt_q;
    completed_cnt_o  = comp_cnt_q;
    idle_o           = (state_q == ST_IDLE) && (busy_q == '0);
    err_done_o       = err_done_q;
  end

endmodule

// File: doc/job_dispatcher.md
Name: job_dispatcher

Overview:
- Sits between the job manager's descriptor output (ready/pull/data) and NUM_ENGINES action engines.
- Pops one descriptor at a time and offers it to a free engine chosen round-robin.
- Tracks per-engine busy state from accept to done, and keeps dispatch/completion counters.
- Provides enable/drain control so software can quiesce the engines.

Parameters:
- NUM_ENGINES, 4, number of engines served (2..16)
- DATA_WIDTH, 1024, descriptor width
- PASID_WIDTH, 9, process number field width; field sits at descriptor bits [992+PASID_WIDTH-1:992]
- CNT_WIDTH, 32, width of dispatch/completion counters

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- enable_i  in  1  1 = fetch new descriptors; 0 = drain
- dsc_ready_i  in  1  descriptor FIFO not empty; dsc_data_i valid while high (first-word-fall-through)
- dsc_data_i  in  DATA_WIDTH  head descriptor
- dsc_pull_o  out  1  one-cycle pop of head descriptor
- eng_valid_o  out  NUM_ENGINES  one-hot offer to the granted engine
- eng_ready_i  in  NUM_ENGINES  engine accepts the offered descriptor
- eng_dsc_o  out  DATA_WIDTH  held descriptor, broadcast to all engines
- eng_pasid_o  out  PASID_WIDTH  PASID field of held descriptor
- eng_done_i  in  NUM_ENGINES  one-cycle job-complete pulse per engine
- eng_busy_o  out  NUM_ENGINES  per-engine busy flags
- dispatched_cnt_o  out  CNT_WIDTH  descriptors accepted by engines
- completed_cnt_o  out  CNT_WIDTH  valid done pulses counted
- idle_o  out  1  no descriptor held and no engine busy
- err_done_o  out  1  sticky: done pulse from an engine that was not busy

Behaviour:
- Reset (resetn=0 at a clk edge) sets state IDLE and clears busy, counters, err_done_o, rr pointer and the holding register.
  - Output reset values: dsc_pull_o=0, eng_valid_o=0, eng_dsc_o=0, eng_pasid_o=0, idle_o=1.
  - A descriptor already pulled but not yet accepted is dropped.
- FSM states: IDLE, OFFER.
- IDLE:
  - go = enable_i & dsc_ready_i & (~busy != 0).
  - dsc_pull_o = go, combinational and asserted in IDLE only.
  - On go: capture dsc_data_i into the holding register, latch grant, move to OFFER.
- Grant: the first free engine (~busy) searching upward from rr pointer with wrap-around, computed from the registered busy vector.
- OFFER:
  - eng_valid_o = one-hot grant (registered, stable until accepted); eng_dsc_o/eng_pasid_o hold their values.
  - On eng_ready_i[grant]: set busy[grant], dispatched_cnt += 1, rr pointer = (grant+1) mod NUM_ENGINES, return to IDLE.
  - eng_ready_i on non-granted engines is ignored.
  - enable_i falling during OFFER does not cancel the offer.
- Throughput is 1 descriptor per 2 cycles minimum. Latency from dsc_ready_i & go to eng_valid_o is 1 cycle.
- Done handling:
  - eng_done_i[k] with busy[k]=1: clear busy[k], completed_cnt += 1.
  - Multiple simultaneous dones each count; the counter adds popcount.
  - Done with busy[k]=0: ignored for busy and counters, sets err_done_o.
  - Done on engine j and accept on engine k in the same cycle are both applied.
  - Done on k and accept on k in the same cycle cannot occur, because the grant requires busy[k]=0.
- A freed engine becomes grantable the cycle after its done pulse (no bypass).
- All engines busy: no pull; stay in IDLE with dsc_ready_i high.
- Counters wrap modulo 2^CNT_WIDTH.
- idle_o = (state==IDLE) & (busy==0), registered-equivalent.
- Drain: enable_i=0 stops fetching. idle_o asserts once all engines finish.

Decomposition:
- Shared package job_pkg: descriptor field offsets (PASID_LSB=992), FSM state encoding, and a round-robin find-first-from-pointer function.
- One sub-module: rr_arbiter (request vector + pointer -> one-hot grant + index), purely combinational, reusable elsewhere in the job manager area.

Test Plan:
- NUM_ENGINES=4, enable=1, 6 descriptors queued, engines accept immediately, no done.
  - Engines 0,1,2,3 each get one in order.
  - The 5th stays in the FIFO (no pull).
  - dispatched_cnt=4, eng_busy=4'b1111.
- Continue the previous scenario: done on engine 2, then engine 0.
  - Next two descriptors go to engine 2 then engine 0 (rr pointer starts at 0 after engine 3).
  - completed_cnt=2.
- Engine 1 holds ready low for 5 cycles while offered.
  - eng_valid_o=4'b0010 and eng_dsc_o stay stable for 5 cycles; no further pull.
  - Accept on cycle 6; next offer 2 cycles later.
- Same-cycle done(engine 3) and accept(engine 1).
  - busy goes from 4'b1000 to 4'b0010.
  - Both counters increment by 1.
- Done on non-busy engine 2.
  - err_done_o=1 and stays set; counters unchanged.
- Drive resetn=0 during OFFER.
  - Next cycle: eng_valid_o=0, busy=0, counters=0, idle_o=1.
  - FIFO head count unchanged by the reset itself.
- Set enable=0 with 2 busy engines and descriptors queued.
  - No pull.
  - idle_o rises the cycle after the last done.
